// File: rtl/alu_mux_bank.sv
// Per-lane 2:1 and 4:1 gate-level mux bank with enable-gated output registers.
// Define ALU_MUX_GATE_DELAY_EN to give every gate primitive a #5 (50 ps) delay.
`timescale 10ps/1ps

module alu_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  logic sel_n;
  logic t0;
  logic t1;

`ifdef ALU_MUX_GATE_DELAY_EN
  not #5 g_inv (sel_n, sel);
  and #5 g_a0  (t0, d0, sel_n);
  and #5 g_a1  (t1, d1, sel);
  or  #5 g_or  (y, t0, t1);
`else
  not g_inv (sel_n, sel);
  and g_a0  (t0, d0, sel_n);
  and g_a1  (t1, d1, sel);
  or  g_or  (y, t0, t1);
`endif
endmodule

module alu_mux4 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);
  logic lo;
  logic hi;

  // Two-level tree: sel[0] picks within {0,1} and {2,3}, sel[1] picks the pair.
  alu_mux2 u_lo  (.d0(d[0]), .d1(d[1]), .sel(sel[0]), .y(lo));
  alu_mux2 u_hi  (.d0(d[2]), .d1(d[3]), .sel(sel[0]), .y(hi));
  alu_mux2 u_top (.d0(lo),   .d1(hi),   .sel(sel[1]), .y(y));
endmodule

module alu_mux_bank #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [2*WIDTH-1:0]   in2,
  input  logic                 sel2,
  input  logic [4*WIDTH-1:0]   in4,
  input  logic [1:0]           sel4,
  output logic [WIDTH-1:0]     out2_c,
  output logic [WIDTH-1:0]     out4_c,
  output logic [WIDTH-1:0]     out2,
  output logic [WIDTH-1:0]     out4
);
  logic [WIDTH-1:0] out2_q;
  logic [WIDTH-1:0] out2_d;
  logic [WIDTH-1:0] out4_q;
  logic [WIDTH-1:0] out4_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    alu_mux2 u_m2 (
      .d0  (in2[2*i]),
      .d1  (in2[2*i+1]),
      .sel (sel2),
      .y   (out2_c[i])
    );
    alu_mux4 u_m4 (
      .d   (in4[4*i +: 4]),
      .sel (sel4),
      .y   (out4_c[i])
    );
  end

  always_comb begin
    out2_d = out2_q;
    out4_d = out4_q;
    if (en) begin
      out2_d = out2_c;
      out4_d = out4_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out2_q <= '0;
      out4_q <= '0;
    end else begin
      out2_q <= out2_d;
      out4_q <= out4_d;
    end
  end

  assign out2 = out2_q;
  assign out4 = out4_q;
endmodule

// File: tb/tb_alu_mux_bank.sv
// Self-checking bench for alu_mux_bank: WIDTH=1 and WIDTH=64 instances against an arithmetic model.
`timescale 10ps/1ps

module tb_alu_mux_bank;
  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         sel2;
  logic [1:0]   sel4;
  logic [1:0]   in2_1;
  logic [3:0]   in4_1;
  logic [127:0] in2_64;
  logic [255:0] in4_64;
  logic [0:0]   o2c_1, o4c_1, o2_1, o4_1;
  logic [63:0]  o2c_64, o4c_64, o2_64, o4_64;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [63:0] exp2_1, exp4_1, exp2_64, exp4_64;

  always #50 clk = ~clk;

  alu_mux_bank #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .en(en),
    .in2(in2_1), .sel2(sel2), .in4(in4_1), .sel4(sel4),
    .out2_c(o2c_1), .out4_c(o4c_1), .out2(o2_1), .out4(o4_1)
  );

  alu_mux_bank #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .en(en),
    .in2(in2_64), .sel2(sel2), .in4(in4_64), .sel4(sel4),
    .out2_c(o2c_64), .out4_c(o4c_64), .out2(o2_64), .out4(o4_64)
  );

  // Lane i picks bit (lane_bits*i + sel) of the packed data word.
  function automatic logic [63:0] mdl2(input logic [127:0] d, input logic s, input int unsigned w);
    logic [63:0] r = '0;
    for (int unsigned i = 0; i < w; i++)
      r[i] = ((d >> (2*i + s)) & 128'd1) != 0;
    return r;
  endfunction

  function automatic logic [63:0] mdl4(input logic [255:0] d, input logic [1:0] s, input int unsigned w);
    logic [63:0] r = '0;
    for (int unsigned i = 0; i < w; i++)
      r[i] = ((d >> (4*i + s)) & 256'd1) != 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb();
    chk("w1_out2_c",  {63'd0, o2c_1}, mdl2({126'd0, in2_1}, sel2, 1));
    chk("w1_out4_c",  {63'd0, o4c_1}, mdl4({252'd0, in4_1}, sel4, 1));
    chk("w64_out2_c", o2c_64, mdl2(in2_64, sel2, 64));
    chk("w64_out4_c", o4c_64, mdl4(in4_64, sel4, 64));
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_w1_out2"},  {63'd0, o2_1}, exp2_1);
    chk({tag, "_w1_out4"},  {63'd0, o4_1}, exp4_1);
    chk({tag, "_w64_out2"}, o2_64, exp2_64);
    chk({tag, "_w64_out4"}, o4_64, exp4_64);
  endtask

  // Advance one rising edge, update the register model, sample 1 unit later.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      exp2_1 = '0; exp4_1 = '0; exp2_64 = '0; exp4_64 = '0;
    end else if (en) begin
      exp2_1  = mdl2({126'd0, in2_1}, sel2, 1);
      exp4_1  = mdl4({252'd0, in4_1}, sel4, 1);
      exp2_64 = mdl2(in2_64, sel2, 64);
      exp4_64 = mdl4(in4_64, sel4, 64);
    end
    #1;
  endtask

  task automatic randomize_inputs();
    in2_1  = 2'($urandom);
    in4_1  = 4'($urandom);
    sel2   = 1'($urandom);
    sel4   = 2'($urandom);
    in2_64 = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 8; k++) in4_64[32*k +: 32] = $urandom;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sel2 = 1'b0; sel4 = 2'd0;
    in2_1 = '0; in4_1 = '0; in2_64 = '0; in4_64 = '0;
    exp2_1 = '0; exp4_1 = '0; exp2_64 = '0; exp4_64 = '0;
    #20;
    chk_regs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Exhaustive WIDTH=1 sweeps of the combinational paths.
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 4; d++) begin
        sel2 = 1'(s); in2_1 = 2'(d); #2;
        chk("sweep2", {63'd0, o2c_1}, mdl2({126'd0, in2_1}, sel2, 1));
      end
    sel2 = 1'b1; in2_1 = 2'b10; #2; chk("ex2_sel1", {63'd0, o2c_1}, 64'd1);
    sel2 = 1'b0;               #2; chk("ex2_sel0", {63'd0, o2c_1}, 64'd0);
    for (int s = 0; s < 4; s++)
      for (int d = 0; d < 16; d++) begin
        sel4 = 2'(s); in4_1 = 4'(d); #2;
        chk("sweep4", {63'd0, o4c_1}, mdl4({252'd0, in4_1}, sel4, 1));
      end
    in4_1 = 4'b1000;
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s); #2;
      chk("ex4_onehot", {63'd0, o4c_1}, (s == 3) ? 64'd1 : 64'd0);
    end

    // WIDTH=64 alternating pattern.
    @(negedge clk);
    in4_64 = {64{4'hA}}; sel4 = 2'd1; #2;
    chk("w64_A_sel1", o4c_64, '1);
    sel4 = 2'd0; #2;
    chk("w64_A_sel0", o4c_64, '0);

    // Registered path: one-edge latency.
    @(negedge clk);
    randomize_inputs(); en = 1'b1; #2;
    chk_regs("pre_edge");
    tick();
    chk_regs("latency");

    // Hold across 3 edges with en=0 while inputs change.
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); randomize_inputs();
      tick();
      chk_regs("hold");
    end

    // Reset mid-cycle with outputs all ones.
    @(negedge clk);
    en = 1'b1; in2_64 = '1; in4_64 = '1; in2_1 = '1; in4_1 = '1;
    tick();
    chk("ones_out4", o4_64, '1);
    #20;
    reset = 1'b1; #1;
    exp2_1 = '0; exp4_1 = '0; exp2_64 = '0; exp4_64 = '0;
    chk_regs("async_rst");
    tick(); chk_regs("rst_hold1");
    tick(); chk_regs("rst_hold2");
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_regs("post_rst");
    chk("post_rst_ones", o4_64, '1);

    // Randomized mixed traffic.
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      randomize_inputs();
      en = 1'($urandom);
      #40;
      chk_comb();
      tick();
      chk_regs("rand");
    end

`ifdef ALU_MUX_GATE_DELAY_EN
    @(negedge clk);
    in4_64 = {64{4'h8}}; sel4 = 2'd0; #40;
    chk("gd_sel0", o4c_64, '0);
    sel4 = 2'd3; #1;
    chk("gd_early", o4c_64, '0);
    #29;
    chk("gd_settled", o4c_64, '1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
